// File: rtl/hazard_pkg.sv
// Shared definitions for the EXE/MEM hazard controller.
//  - RV32 base opcodes used to classify an instruction
//  - forward-select and FSM state encodings
//  - stage_info_t: what the controller remembers about an instruction in EXE or MEM
//  - helpers: producer match, forward-select pick, saturating increment
package hazard_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EXE = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wen;
    logic       is_load;
    logic       is_mem;
  } stage_info_t;

  // True when stage s will write register r; x0 is never a producer.
  function automatic logic stage_hits(input stage_info_t s, input logic [4:0] r);
    return s.valid & s.wen & (s.rd != 5'd0) & (s.rd == r);
  endfunction

  // Youngest producer wins: EXE before MEM, otherwise the register file.
  function automatic fwd_sel_e fwd_pick(input logic use_rs, input logic [4:0] rs,
                                        input stage_info_t exe_s, input stage_info_t mem_s);
    fwd_sel_e sel;
    if (!use_rs) begin
      sel = FWD_RF;
    end else if (stage_hits(exe_s, rs)) begin
      sel = FWD_EXE;
    end else if (stage_hits(mem_s, rs)) begin
      sel = FWD_MEM;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_inst_classify.sv
// inst_classify: purely combinational decode of one instruction for hazard purposes.
// Ports:
//  inst        in   32  instruction word
//  inst_valid  in   1   0 turns the instruction into a bubble (no write, no reads)
//  info        out      {valid, rd, wen, is_load, is_mem}
//  rs1, rs2    out  5   source register fields
//  use_rs1/2   out  1   the instruction really reads that source
module inst_classify
  import hazard_pkg::*;
(
  input  logic [31:0] inst,
  input  logic        inst_valid,
  output stage_info_t info,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        use_rs1,
  output logic        use_rs2
);

  logic is_wr_s;
  logic rd_rs1_s;
  logic rd_rs2_s;
  logic is_ld_s;
  logic is_mem_s;
  // Immediate/funct bits play no part in hazard detection.
  logic unused_bits_s;

  assign unused_bits_s = ^{inst[31:25], inst[14:12]};

  // Opcode class table: who writes rd, who reads rs1/rs2, who touches data memory.
  always_comb begin
    is_wr_s  = 1'b0;
    rd_rs1_s = 1'b0;
    rd_rs2_s = 1'b0;
    is_ld_s  = 1'b0;
    is_mem_s = 1'b0;
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        is_wr_s = 1'b1;
      end
      OPC_JALR, OPC_OP_IMM: begin
        is_wr_s  = 1'b1;
        rd_rs1_s = 1'b1;
      end
      OPC_LOAD: begin
        is_wr_s  = 1'b1;
        rd_rs1_s = 1'b1;
        is_ld_s  = 1'b1;
        is_mem_s = 1'b1;
      end
      OPC_OP: begin
        is_wr_s  = 1'b1;
        rd_rs1_s = 1'b1;
        rd_rs2_s = 1'b1;
      end
      OPC_STORE: begin
        rd_rs1_s = 1'b1;
        rd_rs2_s = 1'b1;
        is_mem_s = 1'b1;
      end
      OPC_BRANCH: begin
        rd_rs1_s = 1'b1;
        rd_rs2_s = 1'b1;
      end
      default: begin
        is_wr_s = 1'b0;
      end
    endcase
  end

  // An invalid slot is a bubble: every qualifier is forced low.
  always_comb begin
    info.valid   = inst_valid;
    info.rd      = inst[11:7];
    info.wen     = inst_valid & is_wr_s;
    info.is_load = inst_valid & is_ld_s;
    info.is_mem  = inst_valid & is_mem_s;
    rs1          = inst[19:15];
    rs2          = inst[24:20];
    use_rs1      = inst_valid & rd_rs1_s;
    use_rs2      = inst_valid & rd_rs2_s;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and sequencing controller for the EXE/MEM datapath.
// Shadows the instructions in EXE and MEM, registers the EXE forward selects,
// detects load-use hazards (one bubble), flushes on branch_taken and freezes the
// core while the data memory has not completed the MEM-stage access.
// Ports:
//  clk, rst                    clock, asynchronous active-high reset
//  dec_inst/dec_valid          instruction in decode (dec_valid=0 -> bubble)
//  branch_taken                kill dec_inst this cycle
//  dmem_ready                  data memory completes the MEM access this cycle
//  exe_rs1/rs2_forward         registered: 0 regfile, 1 exe_result, 2 mem_result
//  freeze_cpu/stall_decode/inject_bubble   combinational pipeline controls
//  dmem_req                    MEM stage holds a load/store
//  dmem_timeout                sticky: raised after WAIT_TIMEOUT consecutive frozen cycles
// Build option: HAZARD_PERF_CNT_EN adds saturating perf counters
//  perf_lu_stalls, perf_freeze_cycles, perf_flushes (32 bits each).
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter logic [31:0] NOP_INST     = 32'h00000013,
  parameter int unsigned WAIT_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dec_inst,
  input  logic        dec_valid,
  input  logic        branch_taken,
  input  logic        dmem_ready,
  output logic [1:0]  exe_rs1_forward,
  output logic [1:0]  exe_rs2_forward,
  output logic        freeze_cpu,
  output logic        stall_decode,
  output logic        inject_bubble,
  output logic        dmem_req,
  output logic        dmem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_lu_stalls,
  output logic [31:0] perf_freeze_cycles,
  output logic [31:0] perf_flushes
`endif
);

  // A bubble carries the NOP's rd but is never valid, so it can never forward.
  localparam stage_info_t BUBBLE_INFO = '{valid: 1'b0, rd: NOP_INST[11:7], wen: 1'b0,
                                          is_load: 1'b0, is_mem: 1'b0};
  localparam logic [15:0] WT_LIM = 16'(WAIT_TIMEOUT);

  stage_info_t dec_info_s;
  stage_info_t exe_q;
  stage_info_t mem_q;
  stage_info_t exe_d_s;
  stage_info_t mem_d_s;
  logic [4:0]  dec_rs1_s;
  logic [4:0]  dec_rs2_s;
  logic        dec_use_rs1_s;
  logic        dec_use_rs2_s;
  hz_state_e   state_r;
  hz_state_e   state_nxt_s;
  logic [1:0]  fwd1_d_s;
  logic [1:0]  fwd2_d_s;
  logic        hold_s;
  logic        lu_hit_s;
  logic [15:0] wait_cnt_r;

  inst_classify u_classify (
    .inst       (dec_inst),
    .inst_valid (dec_valid),
    .info       (dec_info_s),
    .rs1        (dec_rs1_s),
    .rs2        (dec_rs2_s),
    .use_rs1    (dec_use_rs1_s),
    .use_rs2    (dec_use_rs2_s)
  );

  assign dmem_req = mem_q.valid & mem_q.is_mem;

  // During LU_STALL, EXE already holds the bubble, so no second stall can arise.
  assign lu_hit_s = (state_r != LU_STALL) & exe_q.is_load &
                    ((dec_use_rs1_s & stage_hits(exe_q, dec_rs1_s)) |
                     (dec_use_rs2_s & stage_hits(exe_q, dec_rs2_s)));

  // Freeze decision: entered from RUN/LU_STALL on an unfinished access, held in MEM_WAIT until ready.
  always_comb begin
    hold_s = 1'b0;
    case (state_r)
      MEM_WAIT:      hold_s = ~dmem_ready;
      RUN, LU_STALL: hold_s = dmem_req & ~dmem_ready;
      default:       hold_s = 1'b0;
    endcase
  end

  // Next state, shadow updates, forward selects and pipeline controls (freeze > branch > load-use).
  always_comb begin
    state_nxt_s   = state_r;
    exe_d_s       = exe_q;
    mem_d_s       = mem_q;
    fwd1_d_s      = exe_rs1_forward;
    fwd2_d_s      = exe_rs2_forward;
    stall_decode  = 1'b0;
    inject_bubble = 1'b0;
    freeze_cpu    = hold_s;
    if (hold_s) begin
      state_nxt_s = MEM_WAIT;
    end else begin
      mem_d_s     = exe_q;
      state_nxt_s = RUN;
      if (branch_taken) begin
        inject_bubble = 1'b1;
        exe_d_s       = BUBBLE_INFO;
        fwd1_d_s      = FWD_RF;
        fwd2_d_s      = FWD_RF;
      end else if (lu_hit_s) begin
        stall_decode  = 1'b1;
        inject_bubble = 1'b1;
        exe_d_s       = BUBBLE_INFO;
        fwd1_d_s      = FWD_RF;
        fwd2_d_s      = FWD_RF;
        state_nxt_s   = LU_STALL;
      end else begin
        // Selects are judged against the shadows as they stand before dec_inst moves in.
        exe_d_s  = dec_info_s;
        fwd1_d_s = fwd_pick(dec_use_rs1_s, dec_rs1_s, exe_q, mem_q);
        fwd2_d_s = fwd_pick(dec_use_rs2_s, dec_rs2_s, exe_q, mem_q);
      end
    end
  end

  // State, shadow stages and registered forward selects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= RUN;
      exe_q           <= '0;
      mem_q           <= '0;
      exe_rs1_forward <= 2'd0;
      exe_rs2_forward <= 2'd0;
    end else begin
      state_r         <= state_nxt_s;
      exe_q           <= exe_d_s;
      mem_q           <= mem_d_s;
      exe_rs1_forward <= fwd1_d_s;
      exe_rs2_forward <= fwd2_d_s;
    end
  end

  // Consecutive frozen-cycle counter and sticky timeout; the wait itself is never abandoned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r   <= 16'd0;
      dmem_timeout <= 1'b0;
    end else begin
      if (hold_s) begin
        wait_cnt_r <= (wait_cnt_r == 16'hFFFF) ? wait_cnt_r : wait_cnt_r + 16'd1;
      end else begin
        wait_cnt_r <= 16'd0;
      end
      if ((WT_LIM != 16'd0) && hold_s && (wait_cnt_r == WT_LIM - 16'd1)) begin
        dmem_timeout <= 1'b1;
      end else begin
        dmem_timeout <= dmem_timeout;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating event counters: load-use stalls, frozen cycles, branch flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lu_stalls     <= 32'd0;
      perf_freeze_cycles <= 32'd0;
      perf_flushes       <= 32'd0;
    end else begin
      if (stall_decode) begin
        perf_lu_stalls <= sat_inc32(perf_lu_stalls);
      end
      if (freeze_cpu) begin
        perf_freeze_cycles <= sat_inc32(perf_freeze_cycles);
      end
      if (inject_bubble & ~stall_decode) begin
        perf_flushes <= sat_inc32(perf_flushes);
      end
    end
  end
`endif

endmodule
